// File: rtl/seg7_digit_stepper_if.sv
`default_nettype none
// ============================================================================
// Module  : seg7_digit_stepper_if
// Purpose : Button inputs and digit/display outputs of the digit stepper.
// Revision: 1.0  initial release
// ============================================================================
interface seg7_digit_stepper_if;
  logic       btn_up_n;
  logic       btn_dn_n;
  logic [3:0] digit;
  logic       digit_changed;
  logic       dp_n;

  modport master (
    output btn_up_n,
    output btn_dn_n,
    input  digit,
    input  digit_changed,
    input  dp_n
  );

  modport slave (
    input  btn_up_n,
    input  btn_dn_n,
    output digit,
    output digit_changed,
    output dp_n
  );
endinterface
`default_nettype wire

// File: rtl/seg7_digit_stepper.sv
`default_nettype none
// ============================================================================
// Module  : seg7_digit_stepper
// Purpose : Debounced UP/DOWN buttons step a hex digit, with auto-repeat.
// Revision: 1.0  initial release
// ============================================================================
module seg7_digit_stepper #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int WRAP            = 1
) (
  input  wire                   clockIn,
  input  wire                   n_reset,
  seg7_digit_stepper_if.slave   bus
);

  localparam int c_CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_TMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_TIMER_W = (c_TMAX > 2) ? $clog2(c_TMAX) : 1;

  localparam logic [c_CNT_W-1:0]   c_DB_LAST    = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_TIMER_W-1:0] c_DELAY_LOAD = c_TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [c_TIMER_W-1:0] c_RATE_LOAD  = c_TIMER_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } state_t;

  // Bit 0 is the UP button, bit 1 the DOWN button throughout.
  logic [1:0]         r_sync1;
  logic [1:0]         r_sync2;
  logic [1:0]         r_deb;
  logic [1:0]         r_deb_d;
  logic [c_CNT_W-1:0] r_cnt [2];

  state_t               r_state;
  logic [3:0]           r_digit;
  logic                 r_digit_changed;
  logic                 r_dp_n;
  logic [c_TIMER_W-1:0] r_timer;
  logic                 r_dir_up;

  logic [1:0] w_press;
  logic [3:0] w_up_next;
  logic [3:0] w_dn_next;
  logic [3:0] w_held_next;
  logic       w_held_rel;
  logic       w_other_pressed;

  function automatic logic [3:0] step_digit(input logic [3:0] d, input logic up);
    logic [3:0] res;
    if (up) begin
      res = (WRAP == 0 && d == 4'hF) ? d : d + 4'd1;
    end else begin
      res = (WRAP == 0 && d == 4'h0) ? d : d - 4'd1;
    end
    return res;
  endfunction

  // Synchroniser and per-button debounce; only the second flop is trusted.
  always_ff @(posedge clockIn) begin
    if (!n_reset) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_deb    <= 2'b11;
      r_deb_d  <= 2'b11;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1 <= {bus.btn_dn_n, bus.btn_up_n};
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == c_DB_LAST) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_press         = r_deb_d & ~r_deb;
    w_up_next       = step_digit(r_digit, 1'b1);
    w_dn_next       = step_digit(r_digit, 1'b0);
    w_held_next     = r_dir_up ? w_up_next : w_dn_next;
    w_held_rel      = r_dir_up ? r_deb[0]  : r_deb[1];
    w_other_pressed = r_dir_up ? ~r_deb[1] : ~r_deb[0];
  end

  always_ff @(posedge clockIn) begin
    if (!n_reset) begin
      r_state         <= ST_IDLE;
      r_digit         <= 4'h0;
      r_digit_changed <= 1'b0;
      r_dp_n          <= 1'b1;
      r_timer         <= '0;
      r_dir_up        <= 1'b0;
    end else begin
      r_digit_changed <= 1'b0;
      r_dp_n          <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_deb == 2'b00) begin
            r_state <= ST_LOCK;
          end else if (w_press[0] && r_deb[1]) begin
            r_digit         <= w_up_next;
            r_digit_changed <= (w_up_next != r_digit);
            r_dir_up        <= 1'b1;
            r_timer         <= c_DELAY_LOAD;
            r_state         <= ST_HOLD;
          end else if (w_press[1] && r_deb[0]) begin
            r_digit         <= w_dn_next;
            r_digit_changed <= (w_dn_next != r_digit);
            r_dir_up        <= 1'b0;
            r_timer         <= c_DELAY_LOAD;
            r_state         <= ST_HOLD;
          end
        end

        // Release outranks an expiring timer, so letting go never adds a step.
        ST_HOLD, ST_REPEAT: begin
          if (w_held_rel) begin
            r_state <= ST_IDLE;
          end else if (w_other_pressed) begin
            r_state <= ST_LOCK;
          end else if (r_timer == '0) begin
            r_digit         <= w_held_next;
            r_digit_changed <= (w_held_next != r_digit);
            r_timer         <= c_RATE_LOAD;
            r_state         <= ST_REPEAT;
            r_dp_n          <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
            r_dp_n  <= (r_state != ST_REPEAT);
          end
        end

        ST_LOCK: begin
          if (r_deb == 2'b11) begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.digit         = r_digit;
  assign bus.digit_changed = r_digit_changed;
  assign bus.dp_n          = r_dp_n;

endmodule
`default_nettype wire

// File: tb/tb_seg7_digit_stepper.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_digit_stepper
// Purpose : Directed bench for seg7_digit_stepper (wrapping and saturating).
// Revision: 1.0  initial release
// ============================================================================
module tb_seg7_digit_stepper;

  logic clockIn = 1'b0;
  logic n_reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clockIn = ~clockIn;

  seg7_digit_stepper_if a_if ();
  seg7_digit_stepper_if s_if ();

  seg7_digit_stepper #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(1)
  ) dut_wrap (
    .clockIn(clockIn),
    .n_reset(n_reset),
    .bus    (a_if)
  );

  seg7_digit_stepper #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(0)
  ) dut_sat (
    .clockIn(clockIn),
    .n_reset(n_reset),
    .bus    (s_if)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clockIn);
      #1;
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] d, input logic chg, input logic dp);
    check_val({tag, ".digit"}, 32'(a_if.digit), 32'(d));
    check_val({tag, ".chg"},   32'(a_if.digit_changed), 32'(chg));
    check_val({tag, ".dp_n"},  32'(a_if.dp_n), 32'(dp));
  endtask

  initial begin
    n_reset     = 1'b0;
    a_if.btn_up_n = 1'b1;
    a_if.btn_dn_n = 1'b1;
    s_if.btn_up_n = 1'b1;
    s_if.btn_dn_n = 1'b1;
    tick(2);
    check_out("reset", 4'h0, 1'b0, 1'b1);
    check_val("reset.sat_digit", 32'(s_if.digit), 32'h0);
    n_reset = 1'b1;

    // 1: clean press, step lands 7 clocks later
    a_if.btn_up_n = 1'b0;
    tick(6);
    check_out("t1.before", 4'h0, 1'b0, 1'b1);
    tick(1);
    check_out("t1.step", 4'h1, 1'b1, 1'b1);
    tick(1);
    check_out("t1.after", 4'h1, 1'b0, 1'b1);
    tick(2);
    a_if.btn_up_n = 1'b1;
    tick(10);
    check_out("t1.released", 4'h1, 1'b0, 1'b1);

    // 2: glitchy press
    for (int g = 0; g < 3; g++) begin
      a_if.btn_up_n = 1'b0;
      tick(1);
      a_if.btn_up_n = 1'b1;
      tick(2);
    end
    a_if.btn_up_n = 1'b0;
    tick(6);
    check_out("t2.before", 4'h1, 1'b0, 1'b1);
    tick(1);
    check_out("t2.step", 4'h2, 1'b1, 1'b1);
    a_if.btn_up_n = 1'b1;
    tick(10);
    check_out("t2.released", 4'h2, 1'b0, 1'b1);

    // 3: DOWN held from 0 into auto-repeat
    n_reset = 1'b0;
    tick(1);
    n_reset = 1'b1;
    check_out("t3.reset", 4'h0, 1'b0, 1'b1);
    a_if.btn_dn_n = 1'b0;
    tick(7);
    check_out("t3.t0", 4'hF, 1'b1, 1'b1);
    tick(19);
    check_out("t3.t19", 4'hF, 1'b0, 1'b1);
    tick(1);
    check_out("t3.t20", 4'hE, 1'b1, 1'b0);
    tick(4);
    check_out("t3.t24", 4'hE, 1'b0, 1'b0);
    tick(1);
    check_out("t3.t25", 4'hD, 1'b1, 1'b0);
    tick(5);
    check_out("t3.t30", 4'hC, 1'b1, 1'b0);
    tick(5);
    check_out("t3.t35", 4'hB, 1'b1, 1'b0);
    tick(3);
    a_if.btn_dn_n = 1'b1;
    tick(2);
    check_out("t3.t40", 4'hA, 1'b1, 1'b0);
    tick(4);
    check_out("t3.t44", 4'hA, 1'b0, 1'b0);
    // release reaches the FSM in the same cycle the timer expires
    tick(1);
    check_out("t3.t45", 4'hA, 1'b0, 1'b1);
    tick(10);

    // 4: wrap in both directions, then saturation on the WRAP=0 instance
    n_reset = 1'b0;
    tick(1);
    n_reset = 1'b1;
    a_if.btn_dn_n = 1'b0;
    tick(7);
    check_out("t4.wrap_dn", 4'hF, 1'b1, 1'b1);
    a_if.btn_dn_n = 1'b1;
    tick(10);
    a_if.btn_up_n = 1'b0;
    tick(7);
    check_out("t4.wrap_up", 4'h0, 1'b1, 1'b1);
    a_if.btn_up_n = 1'b1;
    tick(10);

    s_if.btn_up_n = 1'b1;
    s_if.btn_up_n = 1'b0;
    tick(7);
    check_val("t4.sat_first", 32'(s_if.digit), 32'h1);
    tick(84);
    check_val("t4.sat_E", 32'(s_if.digit), 32'hE);
    tick(1);
    check_val("t4.sat_F", 32'(s_if.digit), 32'hF);
    check_val("t4.sat_F_chg", 32'(s_if.digit_changed), 32'h1);
    tick(5);
    check_val("t4.sat_hold", 32'(s_if.digit), 32'hF);
    check_val("t4.sat_no_chg", 32'(s_if.digit_changed), 32'h0);
    check_val("t4.sat_dp", 32'(s_if.dp_n), 32'h0);
    s_if.btn_up_n = 1'b1;
    tick(10);

    // 5: simultaneous press locks out stepping
    a_if.btn_up_n = 1'b0;
    a_if.btn_dn_n = 1'b0;
    tick(10);
    check_out("t5.both", 4'h0, 1'b0, 1'b1);
    a_if.btn_dn_n = 1'b1;
    tick(10);
    check_out("t5.dn_rel", 4'h0, 1'b0, 1'b1);
    a_if.btn_up_n = 1'b1;
    tick(10);
    a_if.btn_up_n = 1'b0;
    tick(7);
    check_out("t5.after_lock", 4'h1, 1'b1, 1'b1);
    a_if.btn_up_n = 1'b1;
    tick(10);

    // 6: reset in the middle of auto-repeat with UP still held
    a_if.btn_up_n = 1'b0;
    tick(27);
    check_out("t6.repeat", 4'h3, 1'b1, 1'b0);
    n_reset = 1'b0;
    tick(1);
    n_reset = 1'b1;
    check_out("t6.reset", 4'h0, 1'b0, 1'b1);
    tick(6);
    check_out("t6.before", 4'h0, 1'b0, 1'b1);
    tick(1);
    check_out("t6.redetect", 4'h1, 1'b1, 1'b1);
    a_if.btn_up_n = 1'b1;
    tick(10);
    check_out("t6.end", 4'h1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
